// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 17;
    localparam int DATA_W_DEF = 32;

    typedef enum logic {
        ARB   = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    function automatic logic size_is_ill(input logic [1:0] size);
        return size == SIZE_ILL;
    endfunction

endpackage

// File: rtl/mem_arb_wait_ctr.sv
// Saturating event counter with clear; flags when the count sits at MAX.
// Latency: count updates on the clock edge, sat_o is a registered-state compare.
// Backpressure: none; clr_i together with inc_i loads 1 (start of a new run).
module mem_arb_wait_ctr #(
    parameter int MAX = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = inc_i ? W'(1) : '0;
        end else if (inc_i && (cnt_q != W'(MAX))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat_o = (cnt_q == W'(MAX));

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one data-memory port between the CPU stage (port 0, priority) and a DMA engine (port 1).
// Latency: grant and memory drive are combinational; load data returns one cycle after accept.
// Backpressure: reqN_ready is the grant; port 1 waits at most MAX_WAIT, bursts capped at MAX_BURST beats.
module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_WAIT  = 8,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_write,
    input  logic [1:0]        req0_size,
    input  logic              req0_sign,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_write,
    input  logic [1:0]        req1_size,
    input  logic              req1_sign,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    input  logic              req1_last,

    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,

    output logic              mem_write,
    output logic [1:0]        mem_size,
    output logic              mem_sign,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef struct packed {
        logic              write;
        logic [1:0]        size;
        logic              sign;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    req_t              req0_s, req1_s, sel_s;
    arb_state_e        state_q, state_d;
    logic              grant0, grant1;
    logic              burst_enter, burst_exit;
    logic              wait_sat, wait_inc, wait_clr;
    logic              beat_sat, beat_inc, beat_clr;
    logic [DATA_W-1:0] rsp_dat;
    logic              rsp0_vld_q, rsp1_vld_q;
    logic [DATA_W-1:0] rsp0_rdata_q, rsp1_rdata_q;

    assign req0_s = '{write: req0_write, size: req0_size, sign: req0_sign,
                      addr: req0_addr, wdata: req0_wdata};
    assign req1_s = '{write: req1_write, size: req1_size, sign: req1_sign,
                      addr: req1_addr, wdata: req1_wdata};

    // Grants are held off while reset is asserted so the memory sees an idle port.
    always_comb begin
        state_d     = state_q;
        grant0      = 1'b0;
        grant1      = 1'b0;
        burst_enter = 1'b0;
        burst_exit  = 1'b0;
        if (rst_n) begin
            case (state_q)
                ARB: begin
                    if (req1_valid && wait_sat) begin
                        grant1 = 1'b1;
                    end else if (req0_valid) begin
                        grant0 = 1'b1;
                    end else if (req1_valid) begin
                        grant1 = 1'b1;
                    end
                    burst_enter = grant1 && !req1_last;
                    if (burst_enter) begin
                        state_d = BURST;
                    end
                end
                BURST: begin
                    grant1     = req1_valid;
                    burst_exit = grant1 && (req1_last || beat_sat);
                    if (burst_exit) begin
                        state_d = ARB;
                    end
                end
                default: state_d = ARB;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB;
        end else begin
            state_q <= state_d;
        end
    end

    assign wait_inc = req1_valid && !grant1;
    assign wait_clr = grant1 || !req1_valid;

    mem_arb_wait_ctr #(
        .MAX (MAX_WAIT)
    ) u_wait_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (wait_inc),
        .clr_i (wait_clr),
        .sat_o (wait_sat)
    );

    // Beat counter saturates one short of the cap: the beat accepted at saturation is the last.
    assign beat_clr = (state_q == ARB) || burst_exit;
    assign beat_inc = burst_enter || ((state_q == BURST) && grant1 && !burst_exit);

    mem_arb_wait_ctr #(
        .MAX (MAX_BURST - 1)
    ) u_beat_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (beat_inc),
        .clr_i (beat_clr),
        .sat_o (beat_sat)
    );

    always_comb begin
        sel_s      = '0;
        sel_s.size = SIZE_ILL;
        if (grant0) begin
            sel_s = req0_s;
        end else if (grant1) begin
            sel_s = req1_s;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign mem_write = sel_s.write && !size_is_ill(sel_s.size);
    assign mem_size  = sel_s.size;
    assign mem_sign  = sel_s.sign;
    assign mem_addr  = sel_s.addr;
    assign mem_wdata = sel_s.wdata;

    // Stores and illegal-size accesses return zero rather than whatever the memory drives.
    assign rsp_dat = (sel_s.write || size_is_ill(sel_s.size)) ? '0 : mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_vld_q   <= 1'b0;
            rsp1_vld_q   <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
        end else begin
            rsp0_vld_q <= grant0;
            rsp1_vld_q <= grant1;
            if (grant0) begin
                rsp0_rdata_q <= rsp_dat;
            end
            if (grant1) begin
                rsp1_rdata_q <= rsp_dat;
            end
        end
    end

    assign rsp0_valid = rsp0_vld_q;
    assign rsp1_valid = rsp1_vld_q;
    assign rsp0_rdata = rsp0_rdata_q;
    assign rsp1_rdata = rsp1_rdata_q;

endmodule
